// File: rtl/exu_wbck_arb.sv
// Writeback arbiter: merges ALU and long-pipe writeback requests onto the
// integer register file write port through a single registered stage.
module exu_wbck_arb #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned RFIDX_W    = 5,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               alu_wbck_valid,
    output logic               alu_wbck_ready,
    input  logic [RFIDX_W-1:0] alu_wbck_idx,
    input  logic [XLEN-1:0]    alu_wbck_dat,

    input  logic               longp_wbck_valid,
    output logic               longp_wbck_ready,
    input  logic [RFIDX_W-1:0] longp_wbck_idx,
    input  logic [XLEN-1:0]    longp_wbck_dat,

    output logic               rf_wbck_wen,
    output logic [RFIDX_W-1:0] rf_wbck_idx,
    output logic [XLEN-1:0]    rf_wbck_dat,

    output logic               fwd_valid,
    output logic [3:0]         starve_cnt
);

    localparam int unsigned   CNT_W      = 4;
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic               w_alu_win;
    logic               w_longp_win;
    logic               w_xfer;
    logic [RFIDX_W-1:0] w_sel_idx;
    logic [XLEN-1:0]    w_sel_dat;
    logic [CNT_W-1:0]   w_starve_nxt;

    logic               r_wen;
    logic [RFIDX_W-1:0] r_idx;
    logic [XLEN-1:0]    r_dat;
    logic [CNT_W-1:0]   r_starve_cnt;

    // Long pipe has priority unless the ALU has been starved for STARVE_MAX cycles
    always_comb begin
        w_alu_win    = 1'b0;
        w_longp_win  = 1'b0;
        w_xfer       = 1'b0;
        w_sel_idx    = longp_wbck_idx;
        w_sel_dat    = longp_wbck_dat;
        w_starve_nxt = '0;

        w_alu_win   = alu_wbck_valid && (!longp_wbck_valid || (r_starve_cnt == STARVE_LIM));
        w_longp_win = longp_wbck_valid && !w_alu_win;
        w_xfer      = (w_alu_win || w_longp_win) && !rst;

        if (w_alu_win) begin
            w_sel_idx = alu_wbck_idx;
            w_sel_dat = alu_wbck_dat;
        end

        if (alu_wbck_valid && w_longp_win) begin
            w_starve_nxt = (r_starve_cnt == STARVE_LIM) ? STARVE_LIM
                                                        : r_starve_cnt + CNT_W'(1);
        end
    end

    assign alu_wbck_ready   = w_alu_win && !rst;
    assign longp_wbck_ready = w_longp_win && !rst;

    // Output stage; x0 writes update idx/dat but never raise the strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wen        <= 1'b0;
            r_idx        <= '0;
            r_dat        <= '0;
            r_starve_cnt <= '0;
        end else begin
            r_starve_cnt <= w_starve_nxt;
            r_wen        <= w_xfer && (w_sel_idx != '0);
            if (w_xfer) begin
                r_idx <= w_sel_idx;
                r_dat <= w_sel_dat;
            end
        end
    end

    assign rf_wbck_wen = r_wen;
    assign rf_wbck_idx = r_idx;
    assign rf_wbck_dat = r_dat;
    assign fwd_valid   = r_wen;
    assign starve_cnt  = r_starve_cnt;

endmodule

// File: tb/tb_exu_wbck_arb.sv
// Directed table-driven bench for exu_wbck_arb, plus hand-written reset sequences.
module tb_exu_wbck_arb;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned RFIDX_W = 5;

    logic               clk;
    logic               rst;
    logic               alu_wbck_valid;
    logic               alu_wbck_ready;
    logic [RFIDX_W-1:0] alu_wbck_idx;
    logic [XLEN-1:0]    alu_wbck_dat;
    logic               longp_wbck_valid;
    logic               longp_wbck_ready;
    logic [RFIDX_W-1:0] longp_wbck_idx;
    logic [XLEN-1:0]    longp_wbck_dat;
    logic               rf_wbck_wen;
    logic [RFIDX_W-1:0] rf_wbck_idx;
    logic [XLEN-1:0]    rf_wbck_dat;
    logic               fwd_valid;
    logic [3:0]         starve_cnt;

    exu_wbck_arb #(.XLEN(XLEN), .RFIDX_W(RFIDX_W), .STARVE_MAX(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .alu_wbck_valid   (alu_wbck_valid),
        .alu_wbck_ready   (alu_wbck_ready),
        .alu_wbck_idx     (alu_wbck_idx),
        .alu_wbck_dat     (alu_wbck_dat),
        .longp_wbck_valid (longp_wbck_valid),
        .longp_wbck_ready (longp_wbck_ready),
        .longp_wbck_idx   (longp_wbck_idx),
        .longp_wbck_dat   (longp_wbck_dat),
        .rf_wbck_wen      (rf_wbck_wen),
        .rf_wbck_idx      (rf_wbck_idx),
        .rf_wbck_dat      (rf_wbck_dat),
        .fwd_valid        (fwd_valid),
        .starve_cnt       (starve_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  aidx;
        logic [31:0] adat;
        logic        lv;
        logic [4:0]  lidx;
        logic [31:0] ldat;
        logic        e_ardy;
        logic        e_lrdy;
        logic        e_wen;
        logic [4:0]  e_idx;
        logic [31:0] e_dat;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_pass;
    int   n_total;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic vec_t mk(input logic av, input logic [4:0] aidx, input logic [31:0] adat,
                                input logic lv, input logic [4:0] lidx, input logic [31:0] ldat,
                                input logic e_ardy, input logic e_lrdy, input logic e_wen,
                                input logic [4:0] e_idx, input logic [31:0] e_dat,
                                input logic [3:0] e_cnt);
        vec_t v;
        v.av = av; v.aidx = aidx; v.adat = adat;
        v.lv = lv; v.lidx = lidx; v.ldat = ldat;
        v.e_ardy = e_ardy; v.e_lrdy = e_lrdy; v.e_wen = e_wen;
        v.e_idx = e_idx; v.e_dat = e_dat; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic drive(input logic av, input logic [4:0] aidx, input logic [31:0] adat,
                         input logic lv, input logic [4:0] lidx, input logic [31:0] ldat);
        alu_wbck_valid   = av;
        alu_wbck_idx     = aidx;
        alu_wbck_dat     = adat;
        longp_wbck_valid = lv;
        longp_wbck_idx   = lidx;
        longp_wbck_dat   = ldat;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;

        // ALU-only, idle, collision, x0 write
        vecs.push_back(mk(1, 5'd5, 32'h1234_5678, 0, 5'd0, 32'h0,          1, 0, 1, 5'd5, 32'h1234_5678, 4'd0));
        vecs.push_back(mk(0, 5'd0, 32'h0,         0, 5'd0, 32'h0,          0, 0, 0, 5'd5, 32'h1234_5678, 4'd0));
        vecs.push_back(mk(1, 5'd3, 32'h33,        1, 5'd7, 32'hDEAD_BEEF,  0, 1, 1, 5'd7, 32'hDEAD_BEEF, 4'd1));
        vecs.push_back(mk(0, 5'd0, 32'h0,         1, 5'd0, 32'hFFFF_FFFF,  0, 1, 0, 5'd0, 32'hFFFF_FFFF, 4'd0));
        // Starvation: long pipe wins four times, then the ALU is forced through
        for (int k = 0; k < 4; k++) begin
            vecs.push_back(mk(1, 5'd9, 32'h99, 1, 5'(10 + k), 32'hA0 + 32'(k),
                              0, 1, 1, 5'(10 + k), 32'hA0 + 32'(k), 4'(k + 1)));
        end
        vecs.push_back(mk(1, 5'd9,  32'h99, 1, 5'd14, 32'hA4, 1, 0, 1, 5'd9,  32'h99, 4'd0));
        vecs.push_back(mk(1, 5'd15, 32'hF5, 1, 5'd14, 32'hA4, 0, 1, 1, 5'd14, 32'hA4, 4'd1));
        vecs.push_back(mk(1, 5'd15, 32'hF5, 0, 5'd0,  32'h0,  1, 0, 1, 5'd15, 32'hF5, 4'd0));
        // Streaming: eight back-to-back ALU writes
        for (int i = 1; i <= 8; i++) begin
            vecs.push_back(mk(1, 5'(i), 32'h100 + 32'(i), 0, 5'd0, 32'h0,
                              1, 0, 1, 5'(i), 32'h100 + 32'(i), 4'd0));
        end
        vecs.push_back(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0, 5'd8, 32'h108, 4'd0));

        // Reset state, with requests present to check ready gating
        rst = 1'b1;
        drive(1, 5'd1, 32'h1, 1, 5'd2, 32'h2);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wen",   32'(rf_wbck_wen), 32'd0);
        chk("rst_idx",   32'(rf_wbck_idx), 32'd0);
        chk("rst_dat",   rf_wbck_dat,      32'd0);
        chk("rst_fwd",   32'(fwd_valid),   32'd0);
        chk("rst_cnt",   32'(starve_cnt),  32'd0);
        chk("rst_ardy",  32'(alu_wbck_ready),   32'd0);
        chk("rst_lrdy",  32'(longp_wbck_ready), 32'd0);
        @(negedge clk);
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].av, vecs[i].aidx, vecs[i].adat, vecs[i].lv, vecs[i].lidx, vecs[i].ldat);
            #1;
            chk($sformatf("v%0d_ardy", i), 32'(alu_wbck_ready),   32'(vecs[i].e_ardy));
            chk($sformatf("v%0d_lrdy", i), 32'(longp_wbck_ready), 32'(vecs[i].e_lrdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_wen", i), 32'(rf_wbck_wen), 32'(vecs[i].e_wen));
            chk($sformatf("v%0d_fwd", i), 32'(fwd_valid),   32'(vecs[i].e_wen));
            chk($sformatf("v%0d_idx", i), 32'(rf_wbck_idx), 32'(vecs[i].e_idx));
            chk($sformatf("v%0d_dat", i), rf_wbck_dat,      vecs[i].e_dat);
            chk($sformatf("v%0d_cnt", i), 32'(starve_cnt),  32'(vecs[i].e_cnt));
        end

        // Reset mid-flight: collision transfer, then async reset before next edge
        @(negedge clk);
        drive(1, 5'd20, 32'h2020, 1, 5'd21, 32'h2121);
        @(posedge clk);
        #1;
        chk("mf_wen_pre", 32'(rf_wbck_wen), 32'd1);
        chk("mf_cnt_pre", 32'(starve_cnt),  32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mf_wen",  32'(rf_wbck_wen),      32'd0);
        chk("mf_fwd",  32'(fwd_valid),        32'd0);
        chk("mf_cnt",  32'(starve_cnt),       32'd0);
        chk("mf_ardy", 32'(alu_wbck_ready),   32'd0);
        chk("mf_lrdy", 32'(longp_wbck_ready), 32'd0);
        @(negedge clk);
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post_rst_wen%0d", c), 32'(rf_wbck_wen), 32'd0);
        end

        // x0 write from the ALU side while idx/dat still update
        @(negedge clk);
        drive(1, 5'd0, 32'hCAFE_F00D, 0, 5'd0, 32'h0);
        #1;
        chk("x0a_ardy", 32'(alu_wbck_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("x0a_wen", 32'(rf_wbck_wen), 32'd0);
        chk("x0a_dat", rf_wbck_dat,      32'hCAFE_F00D);
        @(negedge clk);
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
